// File: rtl/sr_flip_pkg.sv
// Shared encodings for the SR flip-flop array: illegal-command policies,
// 2-bit {S,R} command constants and the S=R=1 resolution helper.
package sr_flip_pkg;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_CLR  = 2;
    localparam int POL_TOG  = 3;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_CLR  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_ILL  = 2'b11;

    // Resolves S=R=1; unknown policy values fall back to hold so q never goes X.
    function automatic logic illegal_next(input int policy, input logic q);
        case (policy)
            POL_SET: return 1'b1;
            POL_CLR: return 1'b0;
            POL_TOG: return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/sr_flip_bit.sv
// One SR flip-flop bit: command decode, state register and, when
// SR_FLIP_ILLEGAL_DET_EN is defined, a sticky illegal-command flag.
module sr_flip_bit
    import sr_flip_pkg::*;
#(
    parameter int   ILLEGAL_POLICY = POL_HOLD,
    parameter logic RESET_VAL      = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] cmd_i,
    output logic       q_o
`ifdef SR_FLIP_ILLEGAL_DET_EN
    ,
    output logic       err_o
`endif
);

    logic q_d;
    logic q_q;

    always_comb begin
        // NOTE: q_d gets a default before the case so every path assigns it and no latch is inferred.
        q_d = q_q;
        case (cmd_i)
            CMD_HOLD: q_d = q_q;
            CMD_CLR:  q_d = 1'b0;
            CMD_SET:  q_d = 1'b1;
            CMD_ILL:  q_d = illegal_next(ILLEGAL_POLICY, q_q);
            default:  q_d = q_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all bits update together at the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

`ifdef SR_FLIP_ILLEGAL_DET_EN
    logic err_d;
    logic err_q;

    assign err_d = err_q | (cmd_i == CMD_ILL);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: rtl/sr_flip.sv
// Array of WIDTH independent synchronous SR flip-flops with complemented output.
// Define SR_FLIP_ILLEGAL_DET_EN to add the per-bit sticky err output.
module sr_flip
    import sr_flip_pkg::*;
#(
    parameter int               WIDTH          = 1,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter int               ILLEGAL_POLICY = POL_HOLD
) (
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qbar,
    input  logic               clk,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] sr
`ifdef SR_FLIP_ILLEGAL_DET_EN
    ,
    output logic [WIDTH-1:0]   err
`endif
);

    // Bit pair i of sr is {S, R} for flip-flop i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_flip_bit #(
            .ILLEGAL_POLICY (ILLEGAL_POLICY),
            .RESET_VAL      (RESET_VAL[i])
        ) u_bit (
            .clk_i   (clk),
            .reset_i (reset),
            .cmd_i   (sr[2*i +: 2]),
            .q_o     (q[i])
`ifdef SR_FLIP_ILLEGAL_DET_EN
            ,
            .err_o   (err[i])
`endif
        );
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_sr_flip.sv
// Scoreboard bench for sr_flip: four WIDTH=1 instances (one per illegal policy),
// one WIDTH=1 instance with RESET_VAL=1 and one WIDTH=4 instance.
module tb_sr_flip;

    typedef struct {
        string      tag;
        int         id;
        logic [3:0] q;
        logic [3:0] err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] sr1;
    logic [7:0] sr4;

    logic       q_p   [0:4];
    logic       qb_p  [0:4];
    logic [3:0] q_w4;
    logic [3:0] qb_w4;
`ifdef SR_FLIP_ILLEGAL_DET_EN
    logic       err_p [0:4];
    logic [3:0] err_w4;
`endif

    exp_t       sb[$];
    logic [3:0] mq   [0:5];
    logic [3:0] merr [0:5];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       seen_reset = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_pol
        sr_flip #(.WIDTH(1), .RESET_VAL(1'b0), .ILLEGAL_POLICY(k)) u_dut (
            .q     (q_p[k]),
            .qbar  (qb_p[k]),
            .clk   (clk),
            .reset (reset),
            .sr    (sr1)
`ifdef SR_FLIP_ILLEGAL_DET_EN
            ,
            .err   (err_p[k])
`endif
        );
    end

    sr_flip #(.WIDTH(1), .RESET_VAL(1'b1), .ILLEGAL_POLICY(0)) u_rv1 (
        .q     (q_p[4]),
        .qbar  (qb_p[4]),
        .clk   (clk),
        .reset (reset),
        .sr    (sr1)
`ifdef SR_FLIP_ILLEGAL_DET_EN
        ,
        .err   (err_p[4])
`endif
    );

    sr_flip #(.WIDTH(4), .RESET_VAL(4'b0000), .ILLEGAL_POLICY(0)) u_w4 (
        .q     (q_w4),
        .qbar  (qb_w4),
        .clk   (clk),
        .reset (reset),
        .sr    (sr4)
`ifdef SR_FLIP_ILLEGAL_DET_EN
        ,
        .err   (err_w4)
`endif
    );

    function automatic logic [3:0] q_act(input int id);
        return (id == 5) ? q_w4 : {3'b000, q_p[id]};
    endfunction

    function automatic logic [3:0] qb_act(input int id);
        return (id == 5) ? qb_w4 : {3'b000, qb_p[id]};
    endfunction

`ifdef SR_FLIP_ILLEGAL_DET_EN
    function automatic logic [3:0] err_act(input int id);
        return (id == 5) ? err_w4 : {3'b000, err_p[id]};
    endfunction
`endif

    // Drives one cycle of stimulus, advances the reference model and queues
    // the expected post-edge state of every instance.
    task automatic drive(input logic r, input logic [1:0] s1, input logic [7:0] s4, input string tag);
        int         w;
        int         pol;
        logic [1:0] c;
        exp_t       e;
        reset = r;
        sr1   = s1;
        sr4   = s4;
        for (int id = 0; id < 6; id++) begin
            w   = (id == 5) ? 4 : 1;
            pol = (id < 4) ? id : 0;
            if (r) begin
                mq[id]   = (id == 4) ? 4'h1 : 4'h0;
                merr[id] = 4'h0;
            end else begin
                for (int b = 0; b < w; b++) begin
                    c = (id == 5) ? s4[2*b +: 2] : s1;
                    case (c)
                        2'b01: mq[id][b] = 1'b0;
                        2'b10: mq[id][b] = 1'b1;
                        2'b11: begin
                            merr[id][b] = 1'b1;
                            if (pol == 1) mq[id][b] = 1'b1;
                            else if (pol == 2) mq[id][b] = 1'b0;
                            else if (pol == 3) mq[id][b] = ~mq[id][b];
                        end
                        default: ;
                    endcase
                end
            end
            e.tag = tag;
            e.id  = id;
            e.q   = mq[id];
            e.err = merr[id];
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous qbar/X check on every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (seen_reset) begin
            for (int id = 0; id < 6; id++) begin
                logic [3:0] mask;
                mask = (id == 5) ? 4'hF : 4'h1;
                n_cmp++;
                if ((((q_act(id) ^ qb_act(id)) & mask) !== mask) || $isunknown(q_act(id) & mask)) begin
                    n_fail++;
                    $display("FAIL qbar_check dut%0d: q=%b qbar=%b required qbar=~q and no X", id, q_act(id), qb_act(id));
                end
            end
        end
    end

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 2'b00, 8'h00, "reset");
        tick();
        seen_reset = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (q_act(e.id) !== e.q) begin
                n_fail++;
                $display("FAIL %s dut%0d q: got %b required %b", e.tag, e.id, q_act(e.id), e.q);
            end
`ifdef SR_FLIP_ILLEGAL_DET_EN
            n_cmp++;
            if (err_act(e.id) !== e.err) begin
                n_fail++;
                $display("FAIL %s dut%0d err: got %b required %b", e.tag, e.id, err_act(e.id), e.err);
            end
`endif
        end
        n_cmp++;
        if ({q_p[0], qb_p[0], q_p[4], qb_p[4]} !== 4'b0110) begin
            n_fail++;
            $display("FAIL reset_vals: got q/qbar rv0=%b%b rv1=%b%b required 01 10", q_p[0], qb_p[0], q_p[4], qb_p[4]);
        end
    endtask

    task automatic test_set_clear();
        exp_t       e;
        logic [1:0] seq [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, seq[i], {4{seq[i]}}, "set_clear");
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (q_act(e.id) !== e.q) begin
                    n_fail++;
                    $display("FAIL %s[%0d] dut%0d q: got %b required %b", e.tag, i, e.id, q_act(e.id), e.q);
                end
`ifdef SR_FLIP_ILLEGAL_DET_EN
                n_cmp++;
                if (err_act(e.id) !== e.err) begin
                    n_fail++;
                    $display("FAIL %s[%0d] dut%0d err: got %b required %b", e.tag, i, e.id, err_act(e.id), e.err);
                end
`endif
            end
        end
    endtask

    task automatic test_illegal();
        exp_t       e;
        logic [3:0] want;
        logic [1:0] seq [2] = '{2'b11, 2'b00};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, seq[i], 8'h00, "illegal");
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (q_act(e.id) !== e.q) begin
                    n_fail++;
                    $display("FAIL %s[%0d] dut%0d q: got %b required %b", e.tag, i, e.id, q_act(e.id), e.q);
                end
`ifdef SR_FLIP_ILLEGAL_DET_EN
                n_cmp++;
                if (err_act(e.id) !== e.err) begin
                    n_fail++;
                    $display("FAIL %s[%0d] dut%0d err: got %b required %b", e.tag, i, e.id, err_act(e.id), e.err);
                end
`endif
            end
            // From q=1, policies hold/set/clear/toggle give 1/1/0/0.
            want = 4'b0011;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (q_p[k] !== want[k]) begin
                    n_fail++;
                    $display("FAIL illegal_policy%0d[%0d] q: got %b required %b", k, i, q_p[k], want[k]);
                end
`ifdef SR_FLIP_ILLEGAL_DET_EN
                n_cmp++;
                if (err_p[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL illegal_err%0d[%0d]: got %b required 1", k, i, err_p[k]);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b0, 2'b10, 8'hAA, "pre_set");
            if (i == 1) begin
                // Inputs toggle between edges, including reset: nothing may move until the edge.
                sr1   = 2'b01;
                sr4   = 8'h55;
                reset = 1'b1;
                #3;
                for (int id = 0; id < 6; id++) begin
                    n_cmp++;
                    if (q_act(id) !== mq[id]) begin
                        n_fail++;
                        $display("FAIL between_edges dut%0d q: got %b required %b", id, q_act(id), mq[id]);
                    end
                end
                drive(1'b0, 2'b00, 8'h00, "hold_after_glitch");
            end
            if (i == 2) drive(1'b1, 2'b10, 8'hAA, "reset_vs_set");
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (q_act(e.id) !== e.q) begin
                    n_fail++;
                    $display("FAIL %s dut%0d q: got %b required %b", e.tag, e.id, q_act(e.id), e.q);
                end
`ifdef SR_FLIP_ILLEGAL_DET_EN
                n_cmp++;
                if (err_act(e.id) !== e.err) begin
                    n_fail++;
                    $display("FAIL %s dut%0d err: got %b required %b", e.tag, e.id, err_act(e.id), e.err);
                end
`endif
            end
        end
    endtask

    task automatic test_width4();
        exp_t e;
        drive(1'b0, 2'b00, 8'b10_01_00_11, "width4");
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (q_act(e.id) !== e.q) begin
                n_fail++;
                $display("FAIL %s dut%0d q: got %b required %b", e.tag, e.id, q_act(e.id), e.q);
            end
`ifdef SR_FLIP_ILLEGAL_DET_EN
            n_cmp++;
            if (err_act(e.id) !== e.err) begin
                n_fail++;
                $display("FAIL %s dut%0d err: got %b required %b", e.tag, e.id, err_act(e.id), e.err);
            end
`endif
        end
        n_cmp++;
        if (q_w4 !== 4'b1000) begin
            n_fail++;
            $display("FAIL width4_vector q: got %b required 1000", q_w4);
        end
`ifdef SR_FLIP_ILLEGAL_DET_EN
        n_cmp++;
        if (err_w4 !== 4'b0001) begin
            n_fail++;
            $display("FAIL width4_vector err: got %b required 0001", err_w4);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 11) == 0), 2'($urandom), 8'($urandom), "random");
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (q_act(e.id) !== e.q) begin
                    n_fail++;
                    $display("FAIL %s[%0d] dut%0d q: got %b required %b", e.tag, i, e.id, q_act(e.id), e.q);
                end
`ifdef SR_FLIP_ILLEGAL_DET_EN
                n_cmp++;
                if (err_act(e.id) !== e.err) begin
                    n_fail++;
                    $display("FAIL %s[%0d] dut%0d err: got %b required %b", e.tag, i, e.id, err_act(e.id), e.err);
                end
`endif
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        sr1   = 2'b00;
        sr4   = 8'h00;
        test_reset();
        test_set_clear();
        test_illegal();
        test_reset_priority();
        test_width4();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
